// File: rtl/life_step_controller_if.sv
// life_step_controller_if
//   Groups the control, host-handshake and row-bank strobe signals of the
//   Conway board sequencer. Clock and reset stay plain ports on the block.
//
//   Signals (direction seen from the controller, modport slave):
//     start      in   begin a run of gen_count generations
//     gen_count  in   number of generations, sampled on an accepted start
//     stop       in   finish the current generation's commit, then end the run
//     host_req   in   host write request, held with host_row until host_gnt
//     host_row   in   target row of the host write
//     host_gnt   out  host write accepted this cycle
//     row_sel    out  row index fed to the next-row logic
//     shadow_we  out  one-hot shadow-bank write enable
//     main_we    out  main-bank write enable (one-hot host write / all-ones commit)
//     main_sel   out  main-bank data mux: 0 host data, 1 shadow rows
//     gen_left   out  generations remaining, including the current one
//     busy       out  run in progress (COMPUTE or COMMIT)
//     done       out  one-cycle pulse when a run ends
interface life_step_controller_if #(
  parameter int ROWS   = 11,
  parameter int GEN_W  = 16,
  parameter int RSEL_W = $clog2(ROWS)
);
  logic              start;
  logic [GEN_W-1:0]  gen_count;
  logic              stop;
  logic              host_req;
  logic [RSEL_W-1:0] host_row;
  logic              host_gnt;
  logic [RSEL_W-1:0] row_sel;
  logic [ROWS-1:0]   shadow_we;
  logic [ROWS-1:0]   main_we;
  logic              main_sel;
  logic [GEN_W-1:0]  gen_left;
  logic              busy;
  logic              done;

  // Requester side: drives run control and host requests.
  modport master (
    output start, gen_count, stop, host_req, host_row,
    input  host_gnt, row_sel, shadow_we, main_we, main_sel, gen_left, busy, done
  );

  // Controller side.
  modport slave (
    input  start, gen_count, stop, host_req, host_row,
    output host_gnt, row_sel, shadow_we, main_we, main_sel, gen_left, busy, done
  );
endinterface

// File: rtl/life_step_controller.sv
// life_step_controller
//   Sequencer for the Conway board's row-register bank. It owns every write
//   enable of the main and shadow banks. In IDLE it grants the shared main-bank
//   write port to the host loader; on start it runs gen_count generations,
//   each one ROWS cycles of shadow writes (COMPUTE) followed by one cycle that
//   copies every shadow row into the main bank (COMMIT).
//
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-low reset
//     bus    slave modport of life_step_controller_if (see that file)
module life_step_controller #(
  parameter int ROWS   = 11,
  parameter int GEN_W  = 16,
  parameter int RSEL_W = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  life_step_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [RSEL_W-1:0] ROW_ZERO = {RSEL_W{1'b0}};
  localparam logic [RSEL_W-1:0] ROW_ONE  = {{(RSEL_W-1){1'b0}}, 1'b1};
  localparam logic [RSEL_W-1:0] ROW_LAST = RSEL_W'(ROWS - 32'd1);
  localparam logic [GEN_W-1:0]  GEN_ZERO = {GEN_W{1'b0}};
  localparam logic [GEN_W-1:0]  GEN_ONE  = {{(GEN_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic [RSEL_W-1:0] row_cnt_r;
  logic [GEN_W-1:0]  gen_left_r;
  logic              stop_pending_r;

  logic              host_gnt_s;
  logic [RSEL_W-1:0] row_sel_s;
  logic [ROWS-1:0]   shadow_we_s;
  logic [ROWS-1:0]   main_we_s;
  logic              main_sel_s;
  logic              busy_s;
  logic              done_s;

  // Row index to one-hot enable; indices >= ROWS decode to all zeros, which
  // is what drops an out-of-range host write.
  function automatic logic [ROWS-1:0] row_onehot(input logic [RSEL_W-1:0] idx);
    logic [ROWS-1:0] vec;
    for (int i = 0; i < ROWS; i++) begin
      if (idx == RSEL_W'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode. A stop seen in the COMMIT cycle itself also ends the
  // run, since stop_pending would only be set one cycle too late.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.gen_count != GEN_ZERO) begin
            next_state_s = ST_COMPUTE;
          end else begin
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (row_cnt_r == ROW_LAST) begin
          next_state_s = ST_COMMIT;
        end else begin
          next_state_s = ST_COMPUTE;
        end
      end
      ST_COMMIT: begin
        if ((gen_left_r <= GEN_ONE) || stop_pending_r || bus.stop) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_COMPUTE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Row counter, generation counter and stop latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt_r      <= ROW_ZERO;
      gen_left_r     <= GEN_ZERO;
      stop_pending_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && (bus.gen_count != GEN_ZERO)) begin
            gen_left_r     <= bus.gen_count;
            row_cnt_r      <= ROW_ZERO;
            stop_pending_r <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          if (row_cnt_r == ROW_LAST) begin
            row_cnt_r <= ROW_ZERO;
          end else begin
            row_cnt_r <= row_cnt_r + ROW_ONE;
          end
          if (bus.stop) begin
            stop_pending_r <= 1'b1;
          end
        end
        ST_COMMIT: begin
          // Guarded so the count can never wrap below zero.
          if (gen_left_r != GEN_ZERO) begin
            gen_left_r <= gen_left_r - GEN_ONE;
          end
          if (bus.stop) begin
            stop_pending_r <= 1'b1;
          end
        end
        ST_DONE: begin
          stop_pending_r <= 1'b0;
        end
        default: begin
          row_cnt_r      <= ROW_ZERO;
          stop_pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Output decode. The host grant is gated by reset so every output reads
  // zero while reset is held, even with a request pending.
  always_comb begin
    host_gnt_s  = 1'b0;
    row_sel_s   = ROW_ZERO;
    shadow_we_s = {ROWS{1'b0}};
    main_we_s   = {ROWS{1'b0}};
    main_sel_s  = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // start wins over a host request arriving in the same cycle.
        if (reset && bus.host_req && !bus.start) begin
          host_gnt_s = 1'b1;
          main_we_s  = row_onehot(bus.host_row);
        end else begin
          host_gnt_s = 1'b0;
          main_we_s  = {ROWS{1'b0}};
        end
      end
      ST_COMPUTE: begin
        row_sel_s   = row_cnt_r;
        shadow_we_s = row_onehot(row_cnt_r);
        busy_s      = 1'b1;
      end
      ST_COMMIT: begin
        main_we_s  = {ROWS{1'b1}};
        main_sel_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign bus.host_gnt  = host_gnt_s;
  assign bus.row_sel   = row_sel_s;
  assign bus.shadow_we = shadow_we_s;
  assign bus.main_we   = main_we_s;
  assign bus.main_sel  = main_sel_s;
  assign bus.gen_left  = gen_left_r;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;

endmodule
